// File: rtl/asymfifo_push_packer_if.sv
// Valid/ready byte stream with end-of-packet marker feeding the push packer.
// master drives the stream, slave (the packer) returns ready.
interface asymfifo_push_packer_if #(
    parameter int data_in_width = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [data_in_width-1:0] s_data;
    logic                     s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/asymfifo_push_packer.sv
// Push-side front end for DW_asymfifoctl_s2_sf: turns a byte stream into push/flush
// requests and forces a flush of a packet's trailing partial word at EOP or on idle timeout.
module asymfifo_push_packer #(
    parameter int data_in_width  = 8,
    parameter int data_out_width = 24,
    parameter int timeout        = 16,
    parameter int cnt_width      = 16
) (
    input  logic                     clk_push,
    input  logic                     rst,
    asymfifo_push_packer_if.slave    s,
    input  logic                     push_full,
    input  logic                     part_wd,
    input  logic                     push_error,
    output logic                     push_req_n,
    output logic                     flush_n,
    output logic [data_in_width-1:0] data_in,
    output logic [cnt_width-1:0]     pkt_cnt,
    output logic [cnt_width-1:0]     flush_cnt,
    output logic                     to_flush,
    output logic                     err
);
    localparam int IW = (timeout < 2) ? 1 : $clog2(timeout) + 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(timeout - 1);

    if ((data_out_width % data_in_width) != 0) begin : g_width_check
        $error("data_in_width must divide data_out_width");
    end

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_FLUSH, ST_WAIT_CLR} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [cnt_width-1:0]   pkt_q, pkt_d;
    logic [cnt_width-1:0]   fcnt_q, fcnt_d;
    logic                   to_flag_q, to_flag_d;
    logic                   err_q;
    logic                   ready, accept, flush_req, to_pulse;

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        pkt_d     = pkt_q;
        fcnt_d    = fcnt_q;
        to_flag_d = to_flag_q;
        ready     = 1'b0;
        accept    = 1'b0;
        flush_req = 1'b0;
        to_pulse  = 1'b0;
        case (state_q)
            ST_RUN: begin
                ready  = ~push_full;
                accept = s.s_valid & ready;
                if (accept || !part_wd) begin
                    idle_d = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 1'b1;
                end
                if (accept && s.s_last) begin
                    state_d   = ST_WAIT;
                    pkt_d     = pkt_q + 1'b1;
                    to_flag_d = 1'b0;
                end else if (timeout != 0 && idle_q == IDLE_LAST && part_wd && !accept) begin
                    state_d   = ST_FLUSH;
                    idle_d    = '0;
                    to_flag_d = 1'b1;
                end
            end
            ST_WAIT: begin
                // FIFO part_wd now reflects the final beat of the packet
                idle_d  = '0;
                state_d = part_wd ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (!push_full) begin
                    flush_req = 1'b1;
                    fcnt_d    = fcnt_q + 1'b1;
                    to_pulse  = to_flag_q;
                    state_d   = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_push) begin
        if (rst) begin
            state_q   <= ST_RUN;
            idle_q    <= '0;
            pkt_q     <= '0;
            fcnt_q    <= '0;
            to_flag_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            pkt_q     <= pkt_d;
            fcnt_q    <= fcnt_d;
            to_flag_q <= to_flag_d;
            err_q     <= err_q | push_error;
        end
    end

    // Strobes are gated by rst so nothing reaches the FIFO while in reset
    assign s.s_ready  = ready & ~rst;
    assign push_req_n = ~(accept & ~rst);
    assign flush_n    = ~(flush_req & ~rst);
    assign to_flush   = to_pulse & ~rst;
    assign data_in    = s.s_data;
    assign pkt_cnt    = pkt_q;
    assign flush_cnt  = fcnt_q;
    assign err        = err_q;
endmodule

// File: tb/tb_asymfifo_push_packer.sv
// Directed bench for asymfifo_push_packer with K=3 and timeout=16.
module tb_asymfifo_push_packer;
    logic        clk_push = 1'b0;
    logic        rst;
    logic        push_full, part_wd, push_error;
    logic        push_req_n, flush_n, to_flush, err;
    logic [7:0]  data_in;
    logic [15:0] pkt_cnt, flush_cnt;
    int          n_vec = 0;
    int          n_err = 0;
    int          n;

    asymfifo_push_packer_if #(.data_in_width(8)) sif ();

    asymfifo_push_packer #(
        .data_in_width(8), .data_out_width(24), .timeout(16), .cnt_width(16)
    ) dut (
        .clk_push  (clk_push),
        .rst       (rst),
        .s         (sif.slave),
        .push_full (push_full),
        .part_wd   (part_wd),
        .push_error(push_error),
        .push_req_n(push_req_n),
        .flush_n   (flush_n),
        .data_in   (data_in),
        .pkt_cnt   (pkt_cnt),
        .flush_cnt (flush_cnt),
        .to_flush  (to_flush),
        .err       (err)
    );

    always #5 clk_push = ~clk_push;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_push);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        #1;
        chk("beat_ready", sif.s_ready, 1'b1);
        chk("beat_push_req_n", push_req_n, 1'b0);
        chk("beat_data_in", data_in, d);
        chk("beat_flush_n", flush_n, 1'b1);
        tick();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push_full = 1'b0; part_wd = 1'b0; push_error = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = 8'h5A; sif.s_last = 1'b0;
        tick(); tick();
        chk("rst_ready", sif.s_ready, 1'b0);
        chk("rst_push_req_n", push_req_n, 1'b1);
        chk("rst_flush_n", flush_n, 1'b1);
        chk("rst_to_flush", to_flush, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 16'd0);
        chk("rst_flush_cnt", flush_cnt, 16'd0);
        chk("rst_err", err, 1'b0);
        sif.s_valid = 1'b0; rst = 1'b0;
        tick();

        // aligned 3-byte packet: no flush
        beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b1);
        part_wd = 1'b0; sif.s_valid = 1'b1; sif.s_data = 8'hEE; #1;
        chk("wait_ready", sif.s_ready, 1'b0);
        chk("wait_push_req_n", push_req_n, 1'b1);
        sif.s_valid = 1'b0;
        tick();
        chk("aligned_pkt_cnt", pkt_cnt, 16'd1);
        chk("aligned_flush_cnt", flush_cnt, 16'd0);
        chk("aligned_run_ready", sif.s_ready, 1'b1);

        // 2-byte packet: EOP flush
        beat(8'hB1, 1'b0); beat(8'hB2, 1'b1);
        part_wd = 1'b1; tick();
        chk("eop_flush_n", flush_n, 1'b0);
        chk("eop_to_flush", to_flush, 1'b0);
        chk("eop_push_req_n", push_req_n, 1'b1);
        chk("eop_flush_ready", sif.s_ready, 1'b0);
        tick(); part_wd = 1'b0; #1;
        chk("eop_flush_cnt", flush_cnt, 16'd1);
        chk("waitclr_flush_n", flush_n, 1'b1);
        chk("waitclr_ready", sif.s_ready, 1'b0);
        tick();
        chk("eop_pkt_cnt", pkt_cnt, 16'd2);
        chk("eop_run_ready", sif.s_ready, 1'b1);

        // flush held off while FIFO full
        beat(8'hC1, 1'b0); beat(8'hC2, 1'b1);
        part_wd = 1'b1; tick();
        push_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; chk("full_hold_flush_n", flush_n, 1'b1);
            tick();
        end
        chk("full_hold_flush_cnt", flush_cnt, 16'd1);
        push_full = 1'b0; #1;
        chk("full_release_flush_n", flush_n, 1'b0);
        tick();
        chk("full_release_flush_cnt", flush_cnt, 16'd2);
        part_wd = 1'b0; tick();
        chk("full_pkt_cnt", pkt_cnt, 16'd3);

        // idle timeout flush
        beat(8'hD1, 1'b0);
        part_wd = 1'b1; #1;
        n = 0;
        while (flush_n && n < 40) begin
            tick(); n++;
        end
        chk("timeout_latency", n, 16);
        chk("timeout_flush_n", flush_n, 1'b0);
        chk("timeout_pulse", to_flush, 1'b1);
        tick();
        chk("timeout_flush_cnt", flush_cnt, 16'd3);
        chk("timeout_pulse_end", to_flush, 1'b0);
        part_wd = 1'b0; tick();
        chk("timeout_pkt_cnt", pkt_cnt, 16'd3);

        // backpressure and sticky error
        push_full = 1'b1; sif.s_valid = 1'b1; sif.s_data = 8'hE1; #1;
        chk("bp_ready", sif.s_ready, 1'b0);
        chk("bp_push_req_n", push_req_n, 1'b1);
        chk("bp_data_in", data_in, 8'hE1);
        tick();
        chk("bp_pkt_cnt", pkt_cnt, 16'd3);
        chk("err_before", err, 1'b0);
        push_error = 1'b1; tick();
        push_error = 1'b0; tick();
        chk("err_set", err, 1'b1);
        tick();
        chk("err_sticky", err, 1'b1);
        sif.s_valid = 1'b0; push_full = 1'b0; tick();

        // reset during FLUSH
        beat(8'hF1, 1'b0); beat(8'hF2, 1'b1);
        part_wd = 1'b1; push_full = 1'b1; tick();
        chk("pre_rst_flush_n", flush_n, 1'b1);
        rst = 1'b1; push_full = 1'b0; #1;
        chk("rst_flush_gate", flush_n, 1'b1);
        chk("rst_ready_gate", sif.s_ready, 1'b0);
        tick();
        rst = 1'b0; part_wd = 1'b0; #1;
        chk("post_rst_pkt_cnt", pkt_cnt, 16'd0);
        chk("post_rst_flush_cnt", flush_cnt, 16'd0);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_ready", sif.s_ready, 1'b1);
        chk("post_rst_flush_n", flush_n, 1'b1);
        tick();
        chk("post_rst_no_flush", flush_n, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
